// File: rtl/clock_reset_sequenced_broadcast.sv
// Clock fan-out with staggered per-channel reset release, enable masking and
// software-requested per-channel reset pulses.

module clock_reset_channel #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic rel_wr_i,
    input  logic mask_i,
    input  logic req_i,
    output logic rst_o,
    output logic active_o
);
    localparam int SW = $clog2(HOLD_CYCLES + 1);

    logic [SW-1:0] sc_q, sc_d;
    logic          rst_q, rst_d;

    always_comb begin
        sc_d  = sc_q;
        rst_d = rst_q;
        if (run_i) begin
            if (req_i) begin
                sc_d  = SW'(HOLD_CYCLES);
                rst_d = 1'b1;
            end else if (sc_q != '0) begin
                sc_d  = sc_q - SW'(1);
                // Last counted cycle hands the bit back to the mask.
                rst_d = (sc_q > SW'(1)) | ~mask_i;
            end else begin
                rst_d = ~mask_i;
            end
        end else if (rel_wr_i) begin
            rst_d = ~mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sc_q  <= '0;
            rst_q <= 1'b1;
        end else begin
            sc_q  <= sc_d;
            rst_q <= rst_d;
        end
    end

    assign rst_o    = rst_q;
    assign active_o = (sc_d != '0);
endmodule

module clock_reset_sequenced_broadcast #(
    parameter int NUM_OUT     = 5,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 4
) (
    input  logic               auto_in_clock,
    input  logic               auto_in_reset,
    input  logic [NUM_OUT-1:0] channel_mask,
    input  logic [NUM_OUT-1:0] soft_reset_req,
    output logic [NUM_OUT-1:0] auto_out_clock,
    output logic [NUM_OUT-1:0] auto_out_reset,
    output logic               seq_done,
    output logic               busy
);
    localparam int MAXC = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               done_q, done_d;
    logic               busy_q;
    logic [NUM_OUT-1:0] rel_wr, act;

    assign auto_out_clock = {NUM_OUT{auto_in_clock}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        rel_wr  = '0;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                // Slot length is fixed, so masked channels still consume time.
                for (int i = 0; i < NUM_OUT; i++)
                    rel_wr[i] = (cnt_q == '0) && (idx_q == IW'(i));
                if (cnt_q == '0 && idx_q == IW'(NUM_OUT - 1)) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STAGGER - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN:   done_d = 1'b1;
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge auto_in_clock) begin
        if (auto_in_reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_RUN) | (|act);
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        clock_reset_channel #(.HOLD_CYCLES(HOLD_CYCLES)) u_ch (
            .clk_i    (auto_in_clock),
            .rst_i    (auto_in_reset),
            .run_i    (state_q == S_RUN),
            .rel_wr_i (rel_wr[g]),
            .mask_i   (channel_mask[g]),
            .req_i    (soft_reset_req[g]),
            .rst_o    (auto_out_reset[g]),
            .active_o (act[g])
        );
    end

    assign seq_done = done_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_clock_reset_sequenced_broadcast.sv
// Directed bench: segment table for the default instance plus hand sequences
// for clock fan-out and the 1/1/1 corner instance.

module tb_clock_reset_sequenced_broadcast;
    localparam int N = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_in;
    logic [N-1:0] mask, req, oclk, orst;
    logic         done, busy;

    logic         c_rst;
    logic [0:0]   c_mask, c_req, c_oclk, c_orst;
    logic         c_done, c_busy;

    clock_reset_sequenced_broadcast #(.NUM_OUT(N), .HOLD_CYCLES(8), .STAGGER(4)) dut (
        .auto_in_clock  (clk),
        .auto_in_reset  (rst_in),
        .channel_mask   (mask),
        .soft_reset_req (req),
        .auto_out_clock (oclk),
        .auto_out_reset (orst),
        .seq_done       (done),
        .busy           (busy)
    );

    clock_reset_sequenced_broadcast #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER(1)) dut_c (
        .auto_in_clock  (clk),
        .auto_in_reset  (c_rst),
        .channel_mask   (c_mask),
        .soft_reset_req (c_req),
        .auto_out_clock (c_oclk),
        .auto_out_reset (c_orst),
        .seq_done       (c_done),
        .busy           (c_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Hold inputs for n edges, then expect {auto_out_reset, seq_done, busy}.
    typedef struct {
        int         n;
        logic       r;
        logic [4:0] m;
        logic [4:0] q;
        logic [4:0] e_rst;
        logic       e_done;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int n, input logic r, input logic [4:0] m,
                               input logic [4:0] q, input logic [4:0] er,
                               input logic ed, input logic eb);
        vec_t t;
        t.n = n; t.r = r; t.m = m; t.q = q;
        t.e_rst = er; t.e_done = ed; t.e_busy = eb;
        return t;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    initial begin
        rst_in = 1'b1; mask = 5'h1F; req = '0;
        c_rst  = 1'b1; c_mask = 1'b1; c_req = 1'b0;

        // Bring-up, all channels enabled
        tbl.push_back(v( 3, 1, 5'h1F, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v( 8, 0, 5'h1F, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h1E, 0, 1));
        tbl.push_back(v( 3, 0, 5'h1F, 5'h00, 5'h1E, 0, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h1C, 0, 1));
        tbl.push_back(v( 4, 0, 5'h1F, 5'h00, 5'h18, 0, 1));
        tbl.push_back(v( 4, 0, 5'h1F, 5'h00, 5'h10, 0, 1));
        tbl.push_back(v( 3, 0, 5'h1F, 5'h00, 5'h10, 0, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        // Soft reset on channel 2, then retriggered pulse
        tbl.push_back(v(12, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h04, 5'h04, 1, 1));
        tbl.push_back(v( 7, 0, 5'h1F, 5'h00, 5'h04, 1, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h04, 5'h04, 1, 1));
        tbl.push_back(v( 3, 0, 5'h1F, 5'h00, 5'h04, 1, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h04, 5'h04, 1, 1));
        tbl.push_back(v( 7, 0, 5'h1F, 5'h00, 5'h04, 1, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        // Simultaneous requests on every channel
        tbl.push_back(v( 1, 0, 5'h1F, 5'h1F, 5'h1F, 1, 1));
        tbl.push_back(v( 7, 0, 5'h1F, 5'h00, 5'h1F, 1, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        // Mask toggling, and mask interplay with an active soft reset
        tbl.push_back(v( 1, 0, 5'h1E, 5'h00, 5'h01, 1, 0));
        tbl.push_back(v( 5, 0, 5'h1E, 5'h00, 5'h01, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1E, 5'h01, 5'h01, 1, 1));
        tbl.push_back(v( 4, 0, 5'h1F, 5'h00, 5'h01, 1, 1));
        tbl.push_back(v( 3, 0, 5'h1F, 5'h00, 5'h01, 1, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1E, 5'h01, 5'h01, 1, 1));
        tbl.push_back(v( 8, 0, 5'h1E, 5'h00, 5'h01, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        // Reset mid-sequence; requests during HOLD/RELEASE must be ignored
        tbl.push_back(v( 3, 1, 5'h1F, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v(15, 0, 5'h1F, 5'h00, 5'h1C, 0, 1));
        tbl.push_back(v( 1, 1, 5'h1F, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v( 1, 1, 5'h1F, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v( 9, 0, 5'h1F, 5'h1F, 5'h1E, 0, 1));
        tbl.push_back(v( 4, 0, 5'h1F, 5'h1F, 5'h1C, 0, 1));
        tbl.push_back(v(11, 0, 5'h1F, 5'h1F, 5'h10, 0, 1));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h1F, 5'h00, 1, 0));
        tbl.push_back(v( 1, 0, 5'h1F, 5'h00, 5'h00, 1, 0));
        // Masked bring-up 10101
        tbl.push_back(v( 3, 1, 5'h15, 5'h00, 5'h1F, 0, 1));
        tbl.push_back(v( 9, 0, 5'h15, 5'h00, 5'h1E, 0, 1));
        tbl.push_back(v( 4, 0, 5'h15, 5'h00, 5'h1E, 0, 1));
        tbl.push_back(v( 4, 0, 5'h15, 5'h00, 5'h1A, 0, 1));
        tbl.push_back(v( 7, 0, 5'h15, 5'h00, 5'h1A, 0, 1));
        tbl.push_back(v( 1, 0, 5'h15, 5'h00, 5'h0A, 1, 0));

        foreach (tbl[i]) begin
            rst_in = tbl[i].r;
            mask   = tbl[i].m;
            req    = tbl[i].q;
            tick(tbl[i].n);
            check($sformatf("row%0d{rst,done,busy}", i), 32'({orst, done, busy}),
                  32'({tbl[i].e_rst, tbl[i].e_done, tbl[i].e_busy}));
        end

        // Clock fan-out follows the source on both phases
        check("oclk_high", 32'(oclk), 32'({N{clk}}));
        check("c_oclk_high", 32'(c_oclk), 32'(clk));
        @(negedge clk); #1;
        check("oclk_low", 32'(oclk), 32'({N{clk}}));
        check("c_oclk_low", 32'(c_oclk), 32'(clk));

        // Corner instance NUM_OUT=1, HOLD_CYCLES=1, STAGGER=1
        c_rst = 1'b1; tick(1);
        check("corner_reset", 32'({c_orst, c_done, c_busy}), 32'(3'b101));
        c_rst = 1'b0; tick(1);
        check("corner_hold", 32'({c_orst, c_done, c_busy}), 32'(3'b101));
        tick(1);
        check("corner_release", 32'({c_orst, c_done, c_busy}), 32'(3'b010));
        c_req = 1'b1; tick(1);
        check("corner_soft_on", 32'({c_orst, c_done, c_busy}), 32'(3'b111));
        c_req = 1'b0; tick(1);
        check("corner_soft_off", 32'({c_orst, c_done, c_busy}), 32'(3'b010));
        c_mask = 1'b0; tick(1);
        check("corner_mask_off", 32'({c_orst, c_done, c_busy}), 32'(3'b110));
        c_mask = 1'b1; tick(1);
        check("corner_mask_on", 32'({c_orst, c_done, c_busy}), 32'(3'b010));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clock_reset_sequenced_broadcast.md
Name: clock_reset_sequenced_broadcast

Overview:
- Parametrised successor to the fixed clock/reset broadcast node; fans one clock to NUM_OUT output ports.
- Adds sequenced per-channel reset release, per-channel enable masking and software-requested per-channel reset pulses.
- Sits between the subsystem clock source and downstream clock groups so domains leave reset in a deterministic, staggered order.

Parameters:
- NUM_OUT, 5, number of output channels (1..32).
- HOLD_CYCLES, 8, minimum reset assertion length after global reset and for soft resets (>=1).
- STAGGER, 4, cycles between successive channel releases (>=1).

Ports:
- auto_in_clock  input  1  sole clock.
- auto_in_reset  input  1  synchronous, active-high reset.
- channel_mask  input  NUM_OUT  1 = channel enabled; 0 = channel held in reset.
- soft_reset_req  input  NUM_OUT  per-channel reset request, sampled each cycle.
- auto_out_clock  output  NUM_OUT  every bit = auto_in_clock (combinational, ungated).
- auto_out_reset  output  NUM_OUT  registered per-channel active-high reset.
- seq_done  output  1  registered; release sequence complete.
- busy  output  1  high in HOLD/RELEASE or while any soft-reset counter is active.

Behaviour:
- One clock (auto_in_clock); reset is synchronous and active-high (auto_in_reset). auto_in_reset is sampled on the clock edge like any other input.
- auto_out_clock is a pure fan-out and toggles during reset.
- auto_in_reset high (any state, any cycle):
  - next cycle auto_out_reset = all ones, seq_done = 0, busy = 1;
  - FSM goes to HOLD; hold counter, channel index and all soft counters cleared.
- HOLD: counts cycles with auto_in_reset low. After HOLD_CYCLES such cycles it enters RELEASE; the counter is cleared.
- RELEASE, channel index idx = 0..NUM_OUT-1:
  - on the first cycle of a slot, auto_out_reset[idx] <= ~channel_mask[idx]; visible the following cycle;
  - every slot lasts STAGGER cycles, including masked channels, so timing is mask-independent;
  - channel k deasserts at T+1+k*STAGGER, where T is the first RELEASE cycle;
  - the last channel's release edge also sets seq_done = 1 and moves to RUN.
- RUN:
  - seq_done = 1.
  - soft_reset_req[i] high at cycle c → auto_out_reset[i] high from c+1 for HOLD_CYCLES cycles. It then follows ~channel_mask[i].
  - A request during an active soft reset reloads that channel's counter (extends the pulse).
  - Channels are independent; simultaneous requests are all honoured.
  - channel_mask[i] falling → auto_out_reset[i] high next cycle, held until the mask rises and no soft reset is active. Mask rising → release next cycle.
- soft_reset_req is ignored outside RUN.
- Per-channel counter width = clog2(HOLD_CYCLES+1). The hold/stagger counter width is sized to max(HOLD_CYCLES, STAGGER).
- busy = (state != RUN) | any soft counter nonzero; registered alongside auto_out_reset.

Test Plan:
Defaults NUM_OUT=5, HOLD_CYCLES=8, STAGGER=4 unless noted. Cycle 0 = first sampled edge.
- Bring-up: auto_in_reset high cycles 0-2, low from 3, mask=5'b11111 → HOLD cycles 3-10; auto_out_reset bits fall at 12, 16, 20, 24, 28 (bit0..bit4); seq_done and busy change at 28; auto_out_clock tracks input throughout.
- Masked bring-up: same stimulus, mask=5'b10101 → bits 0, 2, 4 fall at 12, 20, 28; bits 1, 3 stay high; seq_done=1 at 28.
- Soft reset and retrigger, in RUN:
  - soft_reset_req=5'b00100 at cycle 40 only → auto_out_reset[2] high 41-48, low 49; busy high 41-48; other bits untouched.
  - Repeat with an extra pulse at 44 → high 41-52, low 53.
- Reset mid-sequence: auto_in_reset high at cycle 18 (bits 0-1 released) → all bits high and seq_done=0 at 19; deassert at 20 → release sequence repeats from HOLD with identical timing offsets; soft_reset_req pulses during HOLD/RELEASE have no effect.
- Mask toggling in RUN: clear mask[0] at 50 → bit0 high at 51; set at 60 → bit0 low at 61. Set mask while soft reset active → bit stays high until counter expires.
- Corner parameters: NUM_OUT=1, HOLD_CYCLES=1, STAGGER=1, reset low from cycle 3 → HOLD at 3, RELEASE at 4, auto_out_reset[0] low and seq_done high at 5.
